div_arbiter_4ch: RTL and testbench
==================================

DIV_ARBITER_4CH -- requirements
Module: div_arbiter_4ch

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (fixed at 4 in this revision).
REQ-002 The block SHALL have parameter TIMEOUT, default 64, giving the maximum number of cycles spent in WAIT before the operation is aborted.
REQ-003 The block SHALL have the following port: clk  in  1  the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have the following port: reset  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have the following port: req  in  4  per-requester request level.
REQ-006 The block SHALL have the following port: req_dividend  in  96  packed dividends; requester i uses bits [24i+23:24i].
REQ-007 The block SHALL have the following port: req_divisor  in  96  packed divisors, using the same packing as req_dividend.
REQ-008 The block SHALL have the following port: gnt  out  4  one-hot, one-cycle grant pulse.
REQ-009 The block SHALL have the following port: resp_valid  out  4  one-hot, one-cycle response pulse.
REQ-010 The block SHALL have the following port: resp_quotient  out  24  result; valid only while any resp_valid bit is 1.
REQ-011 The block SHALL have the following port: resp_err  out  2  error code: 00 ok, 01 divide-by-zero, 10 timeout; valid with resp_valid.
REQ-012 The block SHALL have the following port: div_start  out  1  one-cycle start pulse to the shared divider core.
REQ-013 The block SHALL have the following port: div_dividend  out  24  operand to the core; held stable from div_start until the response.
REQ-014 The block SHALL have the following port: div_divisor  out  24  operand to the core; held stable from div_start until the response.
REQ-015 The block SHALL have the following port: div_quotient  in  24  core result; sampled only when div_done is 1.
REQ-016 The block SHALL have the following port: div_done  in  1  core completion pulse.
REQ-017 The block SHALL have the following port: busy  out  1  1 whenever the state is not IDLE.

Function
REQ-018 The state machine SHALL have exactly four states: IDLE, ISSUE, WAIT and RESP.
REQ-019 In IDLE with req != 0, the block SHALL select the first asserted requester at or after pointer rr_ptr in cyclic order 0..3.
REQ-020 On that selection, in the same cycle, the block SHALL pulse gnt for the selected requester, latch its operands and index, and register the outcome for the next cycle.
REQ-021 The granted requester's operands SHALL be sampled on the grant cycle only; later changes on its input lanes SHALL be ignored.
REQ-022 When a requester is granted, the next state SHALL be ISSUE if its divisor is nonzero.
REQ-023 When a requester is granted with divisor == 0, the next state SHALL be RESP with quotient 24'hFFFFFF and resp_err 01, and div_start SHALL NOT be asserted.
REQ-024 In ISSUE, div_start SHALL be 1 for exactly one cycle, and the next state SHALL be WAIT with the timeout counter cleared.
REQ-025 In WAIT, the timeout counter SHALL increment each cycle.
REQ-026 In WAIT, when div_done == 1, the block SHALL capture div_quotient, set resp_err 00 and go to RESP.
REQ-027 In WAIT, if the counter reaches TIMEOUT-1 without div_done, the block SHALL go to RESP with quotient 0 and resp_err 10.
REQ-028 If div_done and timeout expiry occur in the same cycle, div_done SHALL win.
REQ-029 In RESP, resp_valid for the latched index SHALL be 1 for one cycle, rr_ptr SHALL become (index+1) mod 4, and the next state SHALL be IDLE.
REQ-030 A div_done received outside WAIT SHALL be ignored.
REQ-031 req withdrawn before grant SHALL be allowed and SHALL NOT cause a grant.
REQ-032 req still asserted after its own grant SHALL be treated as a new request and arbitrated normally.
REQ-033 Minimum request-to-response latency for a valid divide SHALL be 3 cycles plus the core latency (grant, issue, done cycle, resp).
REQ-034 Divide-by-zero latency SHALL be grant followed by resp on the next cycle.
REQ-035 At most one operation SHALL be outstanding at a time; requests arriving in ISSUE, WAIT or RESP SHALL wait until IDLE.
REQ-036 gnt, resp_valid and div_start SHALL each be zero or one-hot at all times.

Reset
REQ-037 While reset is low, the block SHALL immediately set: state IDLE, rr_ptr 0, gnt 0, resp_valid 0, resp_quotient 0, resp_err 00, div_start 0, div_dividend 0, div_divisor 0, busy 0, and the timeout counter 0.
REQ-038 Reset asserted mid-operation SHALL abort the operation with no response, and any later div_done SHALL be ignored per REQ-030.
REQ-039 The first grant after reset release SHALL be possible on the first rising edge with reset high.

Verification
REQ-040 Single request: req=0001, dividend 100, divisor 7, core model with 26-cycle latency -> gnt 0001, one div_start, resp_valid 0001 with quotient 14, resp_err 00.
REQ-041 Round robin: req=1111 held constantly -> grants in the order 0001, 0010, 0100, 1000, 0001, and each resp_valid matches its grant.
REQ-042 Divide by zero: requester 2 with divisor 0 -> gnt 0100, resp_valid 0100 on the next cycle, quotient FFFFFF, err 01, and no div_start.
REQ-043 Timeout: core model never asserts done -> resp_err 10 and quotient 0 exactly TIMEOUT cycles after entering WAIT, after which the block returns to IDLE.
REQ-044 Reset in WAIT: pull reset low mid-WAIT, then the core pulses done -> no resp_valid, busy 0, and the next request is served normally.

Source files
------------

// File: rtl/div_arbiter_4ch.sv
// div_arbiter_4ch: round-robin arbiter sharing one divider core between four requesters.
// Each granted request is checked for divide-by-zero, issued to the core, and bounded by a timeout.
// A one-hot response pulse goes back to the owner, and the operation then retires.
// Timing, with all outputs registered:
//   - gnt and div_start are visible during the first cycle after the selection edge.
//   - resp_valid is visible in the cycle after RESP, when the block is back in IDLE.
module div_arbiter_4ch #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned DW     = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_dividend,
  input  logic [NREQ*DW-1:0]   req_divisor,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      resp_valid,
  output logic [DW-1:0]        resp_quotient,
  output logic [1:0]           resp_err,
  output logic                 div_start,
  output logic [DW-1:0]        div_dividend,
  output logic [DW-1:0]        div_divisor,
  input  logic [DW-1:0]        div_quotient,
  input  logic                 div_done,
  output logic                 busy
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_DBZ = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic [CNT_W-1:0]   tmo_cnt, tmo_cnt_d;
  logic [DW-1:0]      res_q, res_q_d;
  logic [1:0]         res_err, res_err_d;

  logic [NREQ-1:0]    gnt_d, resp_valid_d;
  logic [DW-1:0]      resp_quotient_d;
  logic [1:0]         resp_err_d;
  logic               div_start_d;
  logic [DW-1:0]      div_dividend_d, div_divisor_d;
  logic               busy_d;

  logic               sel_valid;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   cand;
  logic [DW-1:0]      sel_dividend, sel_divisor;

  // Round-robin pick: first asserted request at or after rr_ptr, in cyclic order.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = rr_ptr + IDX_W'(k);
      if (req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Operand lane mux for the selected requester.
  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (sel_idx == IDX_W'(k)) begin
        sel_dividend = req_dividend[k*DW +: DW];
        sel_divisor  = req_divisor[k*DW +: DW];
      end
    end
  end

  // Next-state and next-output logic; pulses default low, data registers hold.
  always_comb begin
    state_d         = state;
    rr_ptr_d        = rr_ptr;
    idx_d           = idx;
    tmo_cnt_d       = tmo_cnt;
    res_q_d         = res_q;
    res_err_d       = res_err;
    gnt_d           = '0;
    resp_valid_d    = '0;
    resp_quotient_d = resp_quotient;
    resp_err_d      = resp_err;
    div_start_d     = 1'b0;
    div_dividend_d  = div_dividend;
    div_divisor_d   = div_divisor;

    unique case (state)
      IDLE: begin
        if (sel_valid) begin
          gnt_d          = NREQ'(1) << sel_idx;
          idx_d          = sel_idx;
          div_dividend_d = sel_dividend;
          div_divisor_d  = sel_divisor;
          if (sel_divisor == '0) begin
            // Divide-by-zero is answered locally; the core never sees it.
            res_q_d   = '1;
            res_err_d = ERR_DBZ;
            state_d   = RESP;
          end else begin
            div_start_d = 1'b1;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        tmo_cnt_d = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        tmo_cnt_d = tmo_cnt + CNT_W'(1);
        // A completion in the expiry cycle still counts as a success.
        if (div_done) begin
          res_q_d   = div_quotient;
          res_err_d = ERR_OK;
          state_d   = RESP;
        end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
          res_q_d   = '0;
          res_err_d = ERR_TMO;
          state_d   = RESP;
        end
      end
      RESP: begin
        resp_valid_d    = NREQ'(1) << idx;
        resp_quotient_d = res_q;
        resp_err_d      = res_err;
        rr_ptr_d        = idx + IDX_W'(1);
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset drops any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      idx           <= '0;
      tmo_cnt       <= '0;
      res_q         <= '0;
      res_err       <= ERR_OK;
      gnt           <= '0;
      resp_valid    <= '0;
      resp_quotient <= '0;
      resp_err      <= ERR_OK;
      div_start     <= 1'b0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      busy          <= 1'b0;
    end else begin
      state         <= state_d;
      rr_ptr        <= rr_ptr_d;
      idx           <= idx_d;
      tmo_cnt       <= tmo_cnt_d;
      res_q         <= res_q_d;
      res_err       <= res_err_d;
      gnt           <= gnt_d;
      resp_valid    <= resp_valid_d;
      resp_quotient <= resp_quotient_d;
      resp_err      <= resp_err_d;
      div_start     <= div_start_d;
      div_dividend  <= div_dividend_d;
      div_divisor   <= div_divisor_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_div_arbiter_4ch.sv
// tb_div_arbiter_4ch: directed scenarios for div_arbiter_4ch with a simple latency-programmable core model.
module tb_div_arbiter_4ch;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned DW      = 24;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   req_dividend;
  logic [NREQ*DW-1:0]   req_divisor;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      resp_valid;
  logic [DW-1:0]        resp_quotient;
  logic [1:0]           resp_err;
  logic                 div_start;
  logic [DW-1:0]        div_dividend;
  logic [DW-1:0]        div_divisor;
  logic [DW-1:0]        div_quotient = '0;
  logic                 div_done = 1'b0;
  logic                 busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Core model controls
  bit        core_en  = 1'b1;
  int        core_lat = 26;
  int        core_cnt = 0;
  logic [DW-1:0] core_q = '0;

  div_arbiter_4ch #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .gnt           (gnt),
    .resp_valid    (resp_valid),
    .resp_quotient (resp_quotient),
    .resp_err      (resp_err),
    .div_start     (div_start),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_quotient  (div_quotient),
    .div_done      (div_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shared divider core: done pulses core_lat cycles after a sampled div_start.
  always @(negedge clk) begin
    if (div_done) div_done = 1'b0;
    if (core_cnt > 0) begin
      core_cnt = core_cnt - 1;
      if (core_cnt == 0) begin
        div_done     = 1'b1;
        div_quotient = core_q;
      end
    end
    if (div_start && core_en && div_divisor != '0) begin
      core_cnt = core_lat;
      core_q   = div_dividend / div_divisor;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_lane(input int i, input logic [DW-1:0] dvd, input logic [DW-1:0] dvs);
    req_dividend[i*DW +: DW] = dvd;
    req_divisor[i*DW +: DW]  = dvs;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req   = 4'b0001;
    set_lane(0, 24'd100, 24'd7);
    repeat (3) @(negedge clk);
    checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    checks++; if (resp_valid !== 4'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0000", resp_valid); end
    checks++; if (resp_quotient !== 24'h0) begin errors++; $display("FAIL reset_quotient: got %h want 000000", resp_quotient); end
    checks++; if (resp_err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", resp_err); end
    checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL reset_div_start: got %b want 0", div_start); end
    checks++; if (div_dividend !== 24'h0) begin errors++; $display("FAIL reset_div_dividend: got %h want 0", div_dividend); end
    checks++; if (div_divisor !== 24'h0) begin errors++; $display("FAIL reset_div_divisor: got %h want 0", div_divisor); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b1;
  endtask

  // Request held through reset release: granted on the first edge, 100/7 with 26-cycle core.
  task automatic test_single();
    int g_cyc;
    int nstart;
    bit found;
    core_lat = 26;
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    checks++; if (div_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b want 1", div_start); end
    checks++; if (div_dividend !== 24'd100) begin errors++; $display("FAIL single_dividend: got %0d want 100", div_dividend); end
    checks++; if (div_divisor !== 24'd7) begin errors++; $display("FAIL single_divisor: got %0d want 7", div_divisor); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    g_cyc  = cyc;
    nstart = 1;
    found  = 1'b0;
    req    = 4'b0000;
    set_lane(0, 24'd999, 24'd3);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (div_start) nstart++;
      if (resp_valid != 4'b0) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL single_resp_seen: got none want resp"); end
    checks++; if (cyc - g_cyc !== 28) begin errors++; $display("FAIL single_latency: got %0d want 28", cyc - g_cyc); end
    checks++; if (resp_valid !== 4'b0001) begin errors++; $display("FAIL single_resp_valid: got %b want 0001", resp_valid); end
    checks++; if (resp_quotient !== 24'd14) begin errors++; $display("FAIL single_quotient: got %0d want 14", resp_quotient); end
    checks++; if (resp_err !== 2'b00) begin errors++; $display("FAIL single_err: got %b want 00", resp_err); end
    checks++; if (nstart !== 1) begin errors++; $display("FAIL single_start_count: got %0d want 1", nstart); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_after: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0]    exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [DW-1:0] exp_q [5] = '{24'd333, 24'd500, 24'd600, 24'd666, 24'd333};
    int ng = 0;
    int nr = 0;
    int bad1h = 0;
    set_lane(0, 24'd1000, 24'd3);
    set_lane(1, 24'd2000, 24'd4);
    set_lane(2, 24'd3000, 24'd5);
    set_lane(3, 24'd4000, 24'd6);
    core_lat = 4;
    apply_reset();
    req = 4'b1111;
    for (int i = 0; i < 400 && nr < 5; i++) begin
      @(negedge clk);
      if (!$onehot0(gnt) || !$onehot0(resp_valid)) bad1h++;
      if (gnt != 4'b0) begin
        checks++;
        if (ng < 5 && gnt !== exp_g[ng]) begin errors++; $display("FAIL rr_gnt%0d: got %b want %b", ng, gnt, exp_g[ng]); end
        else if (ng >= 5) begin errors++; $display("FAIL rr_extra_gnt: got %b want none", gnt); end
        ng++;
        if (ng == 5) req = 4'b0000;
      end
      if (resp_valid != 4'b0) begin
        checks++;
        if (resp_valid !== exp_g[nr]) begin errors++; $display("FAIL rr_resp%0d: got %b want %b", nr, resp_valid, exp_g[nr]); end
        checks++;
        if (resp_quotient !== exp_q[nr]) begin errors++; $display("FAIL rr_q%0d: got %0d want %0d", nr, resp_quotient, exp_q[nr]); end
        nr++;
      end
    end
    req = 4'b0000;
    checks++; if (nr !== 5) begin errors++; $display("FAIL rr_resp_count: got %0d want 5", nr); end
    checks++; if (bad1h !== 0) begin errors++; $display("FAIL rr_onehot: got %0d violations want 0", bad1h); end
  endtask

  task automatic test_div_by_zero();
    set_lane(2, 24'd55, 24'd0);
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    req = 4'b0000;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL dbz_gnt: got %b want 0100", gnt); end
    checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL dbz_start_g: got %b want 0", div_start); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dbz_busy: got %b want 1", busy); end
    @(negedge clk);
    checks++; if (resp_valid !== 4'b0100) begin errors++; $display("FAIL dbz_resp: got %b want 0100", resp_valid); end
    checks++; if (resp_quotient !== 24'hFFFFFF) begin errors++; $display("FAIL dbz_q: got %h want FFFFFF", resp_quotient); end
    checks++; if (resp_err !== 2'b01) begin errors++; $display("FAIL dbz_err: got %b want 01", resp_err); end
    checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL dbz_start_r: got %b want 0", div_start); end
  endtask

  // Core never completes; a request pulsed during WAIT must not be granted.
  task automatic test_timeout();
    int s_cyc;
    int ng = 0;
    bit found = 1'b0;
    core_en = 1'b0;
    set_lane(1, 24'd50, 24'd5);
    req = 4'b0010;
    @(negedge clk);
    req = 4'b0000;
    checks++; if (gnt !== 4'b0010 || div_start !== 1'b1) begin errors++; $display("FAIL tmo_issue: got gnt=%b start=%b want 0010/1", gnt, div_start); end
    s_cyc = cyc;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == 5) req = 4'b1000;
      if (i == 8) req = 4'b0000;
      if (gnt != 4'b0) ng++;
      if (resp_valid != 4'b0) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL tmo_resp_seen: got none want resp"); end
    checks++; if (cyc - s_cyc !== TIMEOUT + 2) begin errors++; $display("FAIL tmo_latency: got %0d want %0d", cyc - s_cyc, TIMEOUT + 2); end
    checks++; if (resp_valid !== 4'b0010) begin errors++; $display("FAIL tmo_resp: got %b want 0010", resp_valid); end
    checks++; if (resp_err !== 2'b10) begin errors++; $display("FAIL tmo_err: got %b want 10", resp_err); end
    checks++; if (resp_quotient !== 24'h0) begin errors++; $display("FAIL tmo_q: got %h want 000000", resp_quotient); end
    checks++; if (ng !== 0) begin errors++; $display("FAIL tmo_withdrawn_gnt: got %0d grants want 0", ng); end
    @(negedge clk);
    checks++; if (gnt !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL tmo_idle: got gnt=%b busy=%b want 0000/0", gnt, busy); end
    core_en = 1'b1;
  endtask

  // Done landing in the last WAIT cycle wins; one cycle later it is ignored and timeout reports.
  task automatic test_done_vs_expiry(input int lat, input logic [1:0] exp_err, input logic [DW-1:0] exp_q);
    int s_cyc;
    bit found = 1'b0;
    core_lat = lat;
    set_lane(3, 24'd700, 24'd7);
    req = 4'b1000;
    @(negedge clk);
    req = 4'b0000;
    checks++; if (div_start !== 1'b1) begin errors++; $display("FAIL edge%0d_start: got %b want 1", lat, div_start); end
    s_cyc = cyc;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (resp_valid != 4'b0) begin found = 1'b1; break; end
    end
    checks++; if (!found || cyc - s_cyc !== TIMEOUT + 2) begin errors++; $display("FAIL edge%0d_latency: got %0d want %0d", lat, cyc - s_cyc, TIMEOUT + 2); end
    checks++; if (resp_err !== exp_err) begin errors++; $display("FAIL edge%0d_err: got %b want %b", lat, resp_err, exp_err); end
    checks++; if (resp_quotient !== exp_q) begin errors++; $display("FAIL edge%0d_q: got %0d want %0d", lat, resp_quotient, exp_q); end
    @(negedge clk);
    checks++; if (resp_valid !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL edge%0d_after: got resp=%b busy=%b want 0000/0", lat, resp_valid, busy); end
  endtask

  task automatic test_reset_in_wait();
    int bad = 0;
    bit found = 1'b0;
    core_lat = 30;
    set_lane(0, 24'd90, 24'd9);
    req = 4'b0001;
    @(negedge clk);
    req = 4'b0000;
    checks++; if (div_start !== 1'b1) begin errors++; $display("FAIL rstw_start: got %b want 1", div_start); end
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || gnt !== 4'b0 || div_start !== 1'b0) begin errors++; $display("FAIL rstw_async: got busy=%b gnt=%b start=%b want 0", busy, gnt, div_start); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid != 4'b0 || busy != 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rstw_stray_done: got %0d bad cycles want 0", bad); end
    core_lat = 5;
    set_lane(3, 24'd81, 24'd9);
    req = 4'b1000;
    @(negedge clk);
    req = 4'b0000;
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL rstw_next_gnt: got %b want 1000", gnt); end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (resp_valid != 4'b0) begin found = 1'b1; break; end
    end
    checks++; if (!found || resp_valid !== 4'b1000) begin errors++; $display("FAIL rstw_next_resp: got %b want 1000", resp_valid); end
    checks++; if (resp_quotient !== 24'd9 || resp_err !== 2'b00) begin errors++; $display("FAIL rstw_next_q: got %0d/%b want 9/00", resp_quotient, resp_err); end
  endtask

  initial begin
    reset        = 1'b0;
    req          = '0;
    req_dividend = '0;
    req_divisor  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_div_by_zero();
    test_timeout();
    test_done_vs_expiry(64, 2'b00, 24'd100);
    test_done_vs_expiry(65, 2'b10, 24'd0);
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
